run_length_detector: RTL
========================

// Module: run_length_detector
//
// PURPOSE
// Parametrised serial run detector: watches single-bit input w and flags when
// the last RUN_LEN enabled samples are all 0 (z0) or all 1 (z1); z = z0 | z1.
// Generalises the fixed four-in-a-row sequence FSM. Adds a programmable run
// length, a sample enable, a synchronous clear, a visible run length/polarity,
// and a saturating count of detection events. Used wherever a lab datapath
// needs run/idle detection on a serial line.
//
// PARAMETERS
// RUN_LEN  4  consecutive identical samples needed to assert z; legal range 2..255
// HIT_W    8  width of the hits counter
// CNT_W    -  localparam = $clog2(RUN_LEN+1); width of run_len
//
// PORTS
// clock    in   1      single clock, rising-edge
// resetn   in   1      asynchronous, active-low reset
// en       in   1      sample enable; w is sampled only when en=1
// clr      in   1      synchronous clear of all state, including hits
// w        in   1      serial data bit
// z        out  1      z0 | z1
// z0       out  1      run of >= RUN_LEN zeros in progress
// z1       out  1      run of >= RUN_LEN ones in progress
// run_bit  out  1      polarity of the current run (0 before first sample)
// run_len  out  CNT_W  length of the current run, saturating at RUN_LEN
// hits     out  HIT_W  number of detections since reset/clr, saturating
//
// BEHAVIOUR
// - State regs: valid (a sample has been taken), run_bit, run_len, hits.
// - resetn=0: all regs and outputs go to 0 immediately, without waiting for clock.
// - clr=1 at an edge: same values as reset. clr has priority over en; a sample
//   presented in the same cycle is discarded.
// - en=0 and clr=0: hold all state.
// - Sample (en=1, clr=0):
//   - if !valid or w != run_bit: run_bit<=w, run_len<=1, valid<=1.
//   - else: run_len <= min(run_len+1, RUN_LEN).
// - Moore outputs, decoded from registers only; no combinational path from w.
//   - z1 = valid & run_bit & (run_len==RUN_LEN)
//   - z0 = valid & ~run_bit & (run_len==RUN_LEN)
// - Latency: z rises in the cycle after the edge that samples the RUN_LEN-th
//   identical bit. z stays high while the run continues. z drops on the edge
//   that samples the opposite bit; run_len=1 in that same cycle.
// - hits increments by 1 on each sample that takes run_len from RUN_LEN-1 to
//   RUN_LEN. A long run counts as one hit. hits saturates at 2^HIT_W-1 and
//   never wraps.
// - A polarity change while saturated (z0 -> z1) needs RUN_LEN more samples
//   before z reasserts. There is no overlap credit.
//
// STRUCTURE
// - No shared package contents are needed beyond the common header for
//   $clog2 use. Constants stay local.
// - One sub-module: sat_counter #(W, MAX). It provides load-1, increment-to-MAX
//   and clear. It is instantiated twice: for run_len (MAX=RUN_LEN) and for
//   hits (MAX=2^HIT_W-1).
//
// TESTING (RUN_LEN=4, HIT_W=8 unless stated)
// 1 reset, en=1, w=0,0,0,0,0 -> z0=z=1 after 4th edge, run_len=4, hits=1; after 5th still hits=1
// 2 w=0,1,0,1,0,1,0,1 -> z=0 throughout, run_len=1, run_bit tracks w, hits=0
// 3 w=1,1,1,1,0 -> z1=1 after 4th edge; after 5th z=0, run_bit=0, run_len=1
// 4 w=0,0, then en=0 for 3 cycles with w=1, then en=1 w=0,0 -> z0=1 only after last edge
// 5 HIT_W=2: 4 separate 4-zero runs split by a 1 -> hits=1,2,3,3 (saturates)
// 6 run_len=3, pulse resetn low between edges -> all outputs 0 before next edge; clr=1 with en=1 -> all cleared, sample dropped

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// Shared helpers for the run length detector.
package run_length_detector_pkg;

   function automatic int cnt_width(input int run_len);
      return $clog2(run_len + 1);
   endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with clear, load-to-one and increment.
// Priority: clear over load-to-one over increment.
module sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (load1)
         q_d = W'(1);
      else if (inc && (q_q != MAX))
         q_d = q_q + 1'b1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         q_q <= '0;
      else
         q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/run_length_detector.sv
// Serial run detector: flags when the last RUN_LEN enabled samples of w are
// identical, and counts detection events with saturation.
module run_length_detector
   import run_length_detector_pkg::*;
#(
   parameter int   RUN_LEN = 4,
   parameter int   HIT_W   = 8,
   localparam int  CNT_W   = cnt_width(RUN_LEN)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             en,
   input  logic             clr,
   input  logic             w,
   output logic             z,
   output logic             z0,
   output logic             z1,
   output logic             run_bit,
   output logic [CNT_W-1:0] run_len,
   output logic [HIT_W-1:0] hits
);

   logic             valid_q, valid_d;
   logic             run_bit_q, run_bit_d;
   logic             new_run, extend, hit_inc, at_max;
   logic [CNT_W-1:0] run_len_w;
   logic [HIT_W-1:0] hits_w;

   always_comb begin
      new_run   = en & (~valid_q | (w != run_bit_q));
      extend    = en & ~new_run;
      // Only the step into RUN_LEN counts, so a long run is a single hit.
      hit_inc   = extend & (run_len_w == CNT_W'(RUN_LEN - 1));
      valid_d   = valid_q;
      run_bit_d = run_bit_q;
      if (clr) begin
         valid_d   = 1'b0;
         run_bit_d = 1'b0;
      end else if (new_run) begin
         valid_d   = 1'b1;
         run_bit_d = w;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_q   <= 1'b0;
         run_bit_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         run_bit_q <= run_bit_d;
      end
   end

   sat_counter #(.W(CNT_W), .MAX(CNT_W'(RUN_LEN))) u_run_len (
      .clock  (clock),
      .resetn (resetn),
      .clr    (clr),
      .load1  (new_run),
      .inc    (extend),
      .q      (run_len_w)
   );

   sat_counter #(.W(HIT_W), .MAX({HIT_W{1'b1}})) u_hits (
      .clock  (clock),
      .resetn (resetn),
      .clr    (clr),
      .load1  (1'b0),
      .inc    (hit_inc),
      .q      (hits_w)
   );

   assign at_max  = (run_len_w == CNT_W'(RUN_LEN));
   assign z1      = valid_q &  run_bit_q & at_max;
   assign z0      = valid_q & ~run_bit_q & at_max;
   assign z       = z0 | z1;
   assign run_bit = run_bit_q;
   assign run_len = run_len_w;
   assign hits    = hits_w;

endmodule
